relu_pool_gen: RTL and testbench
================================

Name: relu_pool_gen

Overview:
- Parametrised ReLU + pooling engine; successor to the fixed 2x2 ReLU/max-pool stage in the CNN feature-extraction chain.
- Reads a channel-major signed feature map from an external input BRAM and applies optional ReLU.
- Pools with a KxK window at stride K, selecting max or average at run time, and writes the result to an external output BRAM.
- BRAM ports are exposed rather than instantiated internally, so one block serves every conv layer.

Parameters:
- DATA_WIDTH, 8, signed element width.
- CHANNELS, 64, feature-map channels.
- IN_HEIGHT, 14, input rows.
- IN_WIDTH, 16, input columns.
- POOL_K, 2, window size and stride; power of two, 2 or 4.
- RD_LATENCY, 2, input BRAM read latency in cycles (1..4).
- IN_ADDR_WIDTH, 14, input address width (must be >= clog2(CHANNELS*IN_HEIGHT*IN_WIDTH)).
- OUT_ADDR_WIDTH, 12, output address width (must be >= clog2(CHANNELS*OUT_H*OUT_W)).
- Derived, not overridable: OUT_H = IN_HEIGHT/POOL_K (floor); OUT_W = IN_WIDTH/POOL_K (floor).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a pass; sampled only in IDLE
- pool_mode  in  1  0 = max, 1 = average; latched at start
- relu_en  in  1  1 = clamp negatives to 0 before pooling; latched at start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- in_addr  out  IN_ADDR_WIDTH  input BRAM address (registered)
- in_re  out  1  read strobe; one element per cycle
- in_dout  in  DATA_WIDTH  input BRAM data, valid RD_LATENCY cycles after the in_re cycle
- out_addr  out  OUT_ADDR_WIDTH  output BRAM address (registered)
- out_din  out  DATA_WIDTH  output data (registered)
- out_we  out  1  output write strobe, one cycle per output element

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, accumulator and valid pipe cleared.
- Reset mid-pass aborts the pass. There is no partial write after the reset edge, and pending read returns are discarded.
- State machine:
  - IDLE: on start, latch pool_mode/relu_en, clear counters, go to READ.
  - READ: lasts exactly POOL_K*POOL_K cycles. in_re=1 and in_addr = c*IN_HEIGHT*IN_WIDTH + (oh*K+kh)*IN_WIDTH + (ow*K+kw). kw is the fastest index, then kh. Go to DRAIN.
  - DRAIN: lasts RD_LATENCY cycles with in_re=0. Go to WRITE.
  - WRITE: one cycle with out_we=1, out_addr = c*OUT_H*OUT_W + oh*OUT_W + ow, and out_din = result. Advance ow, then oh, then c. After the last element go to DONE; otherwise go to READ.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Read return tracking: a RD_LATENCY-deep valid shift register, fed by in_re, marks returning data.
- Per returned element:
  - v = (relu_en && in_dout<0) ? 0 : in_dout.
  - The first element of a window initialises the accumulator; later elements fold in.
- Max mode: signed compare, keep the larger value; ties keep the stored value.
- Average mode:
  - Accumulator is signed, DATA_WIDTH + 2*log2(K) bits, so it cannot overflow.
  - result = acc >>> (2*log2(K)), i.e. floor toward minus infinity.
  - The result always fits DATA_WIDTH; no saturation logic.
- Timing:
  - Window cost is K*K + RD_LATENCY + 1 cycles; the default configuration takes 7 cycles per output.
  - A pass takes CHANNELS*OUT_H*OUT_W windows, plus 1 DONE cycle.
- Boundaries:
  - Odd or non-divisible dimensions: trailing rows/columns that do not fill a window are never read. Example: IN_HEIGHT=14, K=4 reads rows 0..11 only.
  - start while busy is ignored.
  - start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
  - pool_mode/relu_en changes during a pass have no effect.
  - out_addr increments monotonically from 0 to CHANNELS*OUT_H*OUT_W-1 with no gaps.

Test Plan:
- Default params, max mode, relu_en=1, input[i] = (i mod 256) as signed -> output[0] = max(0, in[0], in[1], in[16], in[17]) = 17; 3584 writes; done pulses once, exactly 7*3584+1 cycles after the start-accept cycle.
- Average mode, relu_en=0, window {-1,-2,-3,-4} -> acc=-10, out=-3 (floor); window {1,1,1,2} -> out=1.
- Max mode, relu_en=1, all inputs -128 -> every output 0; relu_en=0 -> every output -128.
- POOL_K=4, IN_HEIGHT=14, IN_WIDTH=16, RD_LATENCY=3 -> OUT_H=3, OUT_W=4; no in_addr ever hits row 12 or 13; 20 cycles per window.
- Reset asserted during DRAIN of window 5 -> next cycle all outputs 0, no out_we; a new start completes a full correct pass.
- start held high throughout a pass -> exactly one pass per accepted start; busy stays low in the DONE cycle, and the next pass begins from the IDLE cycle that follows.

Source files
------------

// File: rtl/relu_pool_gen.sv
// ReLU + KxK/stride-K pooling over a channel-major feature map held in external BRAMs.
// One window is read, drained through the BRAM latency, then written as a single output element.
module relu_pool_gen #(
  parameter int DATA_WIDTH     = 8,
  parameter int CHANNELS       = 64,
  parameter int IN_HEIGHT      = 14,
  parameter int IN_WIDTH       = 16,
  parameter int POOL_K         = 2,
  parameter int RD_LATENCY     = 2,
  parameter int IN_ADDR_WIDTH  = 14,
  parameter int OUT_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pool_mode,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr,
  output logic                      in_re,
  input  logic [DATA_WIDTH-1:0]     in_dout,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_din,
  output logic                      out_we
);
  localparam int OUT_H  = IN_HEIGHT / POOL_K;
  localparam int OUT_W  = IN_WIDTH / POOL_K;
  localparam int SH     = 2 * $clog2(POOL_K);
  localparam int AW     = DATA_WIDTH + SH;
  localparam int CW     = $clog2(CHANNELS + 1);
  localparam int HW     = $clog2(OUT_H + 1);
  localparam int WW     = $clog2(OUT_W + 1);
  localparam int KW     = $clog2(POOL_K);
  localparam int STAGES = RD_LATENCY - 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             c, c_n;
  logic [HW-1:0]             oh, oh_n;
  logic [WW-1:0]             ow, ow_n;
  logic [KW-1:0]             kh, kh_n, kw, kw_n;
  logic [2:0]                lat, lat_n;
  logic                      mode_q, relu_q, first;
  logic [OUT_ADDR_WIDTH-1:0] wr_idx;
  logic [IN_ADDR_WIDTH-1:0]  rd_addr_n;
  logic [STAGES:0]           vld_pipe;
  logic                      ret_vld;
  logic signed [AW-1:0]      acc, acc_nxt, v_ext, res_src;
  logic [DATA_WIDTH-1:0]     res;

  assign busy    = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
  assign done    = (state == S_DONE);
  assign ret_vld = vld_pipe[STAGES];

  always_comb begin
    state_nxt = state;
    c_n   = c;
    oh_n  = oh;
    ow_n  = ow;
    kh_n  = kh;
    kw_n  = kw;
    lat_n = lat;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_READ;
        c_n  = '0;
        oh_n = '0;
        ow_n = '0;
        kh_n = '0;
        kw_n = '0;
      end
      S_READ: if (kw == KW'(POOL_K - 1)) begin
        kw_n = '0;
        if (kh == KW'(POOL_K - 1)) begin
          kh_n      = '0;
          lat_n     = '0;
          state_nxt = S_DRAIN;
        end else kh_n = kh + 1'b1;
      end else kw_n = kw + 1'b1;
      S_DRAIN: if (lat == 3'(RD_LATENCY - 1)) state_nxt = S_WRITE;
               else lat_n = lat + 3'd1;
      S_WRITE: begin
        state_nxt = S_READ;
        if (ow == WW'(OUT_W - 1)) begin
          ow_n = '0;
          if (oh == HW'(OUT_H - 1)) begin
            oh_n = '0;
            if (c == CW'(CHANNELS - 1)) state_nxt = S_DONE;
            else c_n = c + 1'b1;
          end else oh_n = oh + 1'b1;
        end else ow_n = ow + 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // address of the element the next cycle will read; only used when entering/staying in READ
    rd_addr_n = IN_ADDR_WIDTH'(32'(c_n) * (IN_HEIGHT * IN_WIDTH)
                + (32'(oh_n) * POOL_K + 32'(kh_n)) * IN_WIDTH
                + 32'(ow_n) * POOL_K + 32'(kw_n));
  end

  always_comb begin
    v_ext = {{SH{in_dout[DATA_WIDTH-1]}}, in_dout};
    if (relu_q && in_dout[DATA_WIDTH-1]) v_ext = '0;
    if (first)       acc_nxt = v_ext;
    else if (mode_q) acc_nxt = acc + v_ext;
    else             acc_nxt = (v_ext > acc) ? v_ext : acc;
    // the last element of a window lands in the final DRAIN cycle, so fold it in on the way out
    res_src = ret_vld ? acc_nxt : acc;
    res     = mode_q ? DATA_WIDTH'(res_src >>> SH) : DATA_WIDTH'(res_src);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      c        <= '0;
      oh       <= '0;
      ow       <= '0;
      kh       <= '0;
      kw       <= '0;
      lat      <= '0;
      mode_q   <= 1'b0;
      relu_q   <= 1'b0;
      first    <= 1'b0;
      wr_idx   <= '0;
      vld_pipe <= '0;
      acc      <= '0;
      in_re    <= 1'b0;
      in_addr  <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_din  <= '0;
    end else begin
      state    <= state_nxt;
      c        <= c_n;
      oh       <= oh_n;
      ow       <= ow_n;
      kh       <= kh_n;
      kw       <= kw_n;
      lat      <= lat_n;
      vld_pipe <= (vld_pipe << 1) | (STAGES + 1)'(in_re);
      in_re    <= (state_nxt == S_READ);
      if (state_nxt == S_READ) in_addr <= rd_addr_n;
      out_we   <= (state_nxt == S_WRITE);
      if (state_nxt == S_WRITE) begin
        out_addr <= wr_idx;
        out_din  <= res;
      end
      if (ret_vld) acc <= acc_nxt;
      if (state == S_IDLE && start) begin
        mode_q <= pool_mode;
        relu_q <= relu_en;
        wr_idx <= '0;
        first  <= 1'b1;
      end else if (state == S_WRITE) begin
        wr_idx <= wr_idx + 1'b1;
        first  <= 1'b1;
      end else if (ret_vld) begin
        first  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_relu_pool_gen.sv
// Bench for relu_pool_gen: unit a uses default parameters, unit b uses K=4, RD_LATENCY=3, 2 channels.
// Both BRAMs are modelled here; every read address and written element is checked against a plain model.
module tb_relu_pool_gen;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2], start [2], pool_mode [2], relu_en [2];
  logic        busy [2], done [2], in_re [2], out_we [2];
  logic [13:0] in_addr [2];
  logic [7:0]  in_dout [2], out_din [2];
  logic [11:0] out_addr [2];

  logic signed [7:0] mem [2][14336];
  logic [7:0]        pipe [2][4];
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int exp_idx [2], rd_idx [2], done_cnt [2], got0 [2], got1 [2];
  bit cur_mode [2], cur_relu [2];

  relu_pool_gen u_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .pool_mode(pool_mode[0]), .relu_en(relu_en[0]),
    .busy(busy[0]), .done(done[0]), .in_addr(in_addr[0]), .in_re(in_re[0]), .in_dout(in_dout[0]),
    .out_addr(out_addr[0]), .out_din(out_din[0]), .out_we(out_we[0]));

  relu_pool_gen #(.CHANNELS(2), .POOL_K(4), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .pool_mode(pool_mode[1]), .relu_en(relu_en[1]),
    .busy(busy[1]), .done(done[1]), .in_addr(in_addr[1]), .in_re(in_re[1]), .in_dout(in_dout[1]),
    .out_addr(out_addr[1]), .out_din(out_din[1]), .out_we(out_we[1]));

  // BRAM: data for an address presented in cycle t is visible in cycle t+latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= mem[d][in_addr[d]];
      for (int s = 1; s < 4; s++) pipe[d][s] <= pipe[d][s-1];
    end
  end
  assign in_dout[0] = pipe[0][1];
  assign in_dout[1] = pipe[1][2];

  function automatic int pk(int d);   return (d == 0) ? 2 : 4;  endfunction
  function automatic int pl(int d);   return (d == 0) ? 2 : 3;  endfunction
  function automatic int pc(int d);   return (d == 0) ? 64 : 2; endfunction
  function automatic int nwin(int d); return pc(d) * (14 / pk(d)) * (16 / pk(d)); endfunction
  function automatic int win(int d);  return pk(d) * pk(d) + pl(d) + 1; endfunction
  function automatic string u(int d); return (d == 0) ? "a_" : "b_"; endfunction

  function automatic int exp_rd(int d, int k);
    int kk, w, e, ow, oh, c;
    kk = pk(d) * pk(d);
    w  = k / kk;
    e  = k % kk;
    ow = w % (16 / pk(d));
    oh = (w / (16 / pk(d))) % (14 / pk(d));
    c  = w / ((16 / pk(d)) * (14 / pk(d)));
    return c * 224 + (oh * pk(d) + e / pk(d)) * 16 + ow * pk(d) + e % pk(d);
  endfunction

  function automatic int model(int d, int idx);
    int k, ow, oh, c, v, best, sum, n;
    k = pk(d);
    ow = idx % (16 / k);
    oh = (idx / (16 / k)) % (14 / k);
    c  = idx / ((16 / k) * (14 / k));
    best = 0;
    sum  = 0;
    for (int r = 0; r < k; r++)
      for (int s = 0; s < k; s++) begin
        v = mem[d][c * 224 + (oh * k + r) * 16 + ow * k + s];
        if (cur_relu[d] && v < 0) v = 0;
        if ((r == 0 && s == 0) || v > best) best = v;
        sum += v;
      end
    n = k * k;
    if (!cur_mode[d]) return best;
    return (sum >= 0) ? sum / n : -((-sum + n - 1) / n);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon();
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        exp_idx[d] = 0;
        rd_idx[d]  = 0;
      end
      if (in_re[d]) begin
        check({u(d), "rd_addr"}, in_addr[d], exp_rd(d, rd_idx[d]));
        if (d == 1) check("b_row_in_window", int'((in_addr[d] / 16) % 14 < 12), 1);
        rd_idx[d]++;
      end
      if (out_we[d]) begin
        check({u(d), "out_addr"}, out_addr[d], exp_idx[d]);
        check({u(d), "out_data"}, $signed(out_din[d]), model(d, exp_idx[d]));
        if (exp_idx[d] == 0) got0[d] = $signed(out_din[d]);
        if (exp_idx[d] == 1) got1[d] = $signed(out_din[d]);
        exp_idx[d]++;
      end
      if (done[d]) begin
        check({u(d), "busy_in_done"}, busy[d], 0);
        check({u(d), "write_count"}, exp_idx[d], nwin(d));
        done_cnt[d]++;
        exp_idx[d] = 0;
        rd_idx[d]  = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic run_pass(input int d, input bit mode, input bit relu, input bit hold, input bit wiggle);
    int t0, n;
    start[d] = 1'b1;
    pool_mode[d] = mode;
    relu_en[d] = relu;
    cur_mode[d] = mode;
    cur_relu[d] = relu;
    t0 = cyc;
    tick();
    check({u(d), "busy_after_start"}, busy[d], 1);
    if (!hold) start[d] = 1'b0;
    n = 0;
    while (!done[d] && n < nwin(d) * win(d) + 10) begin
      if (wiggle) begin
        pool_mode[d] = 1'($urandom);
        relu_en[d]   = 1'($urandom);
      end
      tick();
      n++;
    end
    if (done[d]) check({u(d), "done_latency"}, cyc - t0, nwin(d) * win(d) + 1);
    else         check({u(d), "done_timeout"}, 0, 1);
    pool_mode[d] = mode;
    relu_en[d]   = relu;
    if (!hold) tick();
  endtask

  initial begin
    int t0, n, base;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; pool_mode[d] = 1'b0; relu_en[d] = 1'b0;
      exp_idx[d] = 0; rd_idx[d] = 0; done_cnt[d] = 0; got0[d] = 0; got1[d] = 0;
      cur_mode[d] = 1'b0; cur_relu[d] = 1'b0;
      for (int i = 0; i < 14336; i++) mem[d][i] = 8'sd0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check({u(d), "rst_busy"}, busy[d], 0);
      check({u(d), "rst_done"}, done[d], 0);
      check({u(d), "rst_in_re"}, in_re[d], 0);
      check({u(d), "rst_out_we"}, out_we[d], 0);
      check({u(d), "rst_in_addr"}, in_addr[d], 0);
      check({u(d), "rst_out_addr"}, out_addr[d], 0);
      check({u(d), "rst_out_din"}, out_din[d], 0);
      rst[d] = 1'b0;
    end
    tick();

    // index pattern, max + ReLU, mode inputs toggling mid-pass
    for (int i = 0; i < 14336; i++) mem[0][i] = 8'(i);
    run_pass(0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("a_first_out", got0[0], 17);
    check("a_done_pulses", done_cnt[0], 1);

    // saturated negative input, with and without ReLU
    for (int i = 0; i < 14336; i++) mem[1][i] = -8'sd128;
    run_pass(1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b_neg_relu", got0[1], 0);
    run_pass(1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b_neg_norelu", got0[1], -128);

    // random data in both modes on the K=4 unit
    for (int i = 0; i < 14336; i++) mem[1][i] = 8'($urandom);
    run_pass(1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_pass(1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_pass(1, 1'b0, 1'b0, 1'b0, 1'b1);

    // start held high: DONE ignores it, the following IDLE accepts it
    for (int i = 0; i < 14336; i++) mem[1][i] = 8'($urandom);
    base = done_cnt[1];
    run_pass(1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("b_idle_after_done", busy[1], 0);
    tick();
    check("b_restart_busy", busy[1], 1);
    start[1] = 1'b0;
    n = 0;
    while (!done[1] && n < 600) begin tick(); n++; end
    check("b_second_done", done[1], 1);
    repeat (30) tick();
    check("b_passes_held", done_cnt[1] - base, 2);
    check("b_no_extra_pass", busy[1], 0);

    // reset during DRAIN of window 5, then a full average pass
    for (int i = 0; i < 14336; i++) mem[0][i] = 8'($urandom);
    mem[0][0] = -8'sd1; mem[0][1] = -8'sd2; mem[0][16] = -8'sd3; mem[0][17] = -8'sd4;
    mem[0][2] = 8'sd1;  mem[0][3] = 8'sd1;  mem[0][18] = 8'sd1;  mem[0][19] = 8'sd2;
    start[0] = 1'b1; pool_mode[0] = 1'b1; relu_en[0] = 1'b0;
    cur_mode[0] = 1'b1; cur_relu[0] = 1'b0;
    t0 = cyc;
    tick();
    start[0] = 1'b0;
    while (cyc < t0 + 33) tick();
    check("a_writes_before_rst", exp_idx[0], 4);
    rst[0] = 1'b1;
    tick();
    check("a_abort_busy", busy[0], 0);
    check("a_abort_we", out_we[0], 0);
    check("a_abort_re", in_re[0], 0);
    check("a_abort_out_addr", out_addr[0], 0);
    check("a_abort_out_din", out_din[0], 0);
    check("a_abort_in_addr", in_addr[0], 0);
    rst[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_no_we_after_rst", out_we[0], 0);
    end
    run_pass(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a_avg_floor_neg", got0[0], -3);
    check("a_avg_pos", got1[0], 1);
    check("a_done_pulses_total", done_cnt[0], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
